// File: rtl/multi_timer.sv
// multi_timer: NCH independent down-counting timers behind a word-addressed register file.
// Define MULTI_TIMER_PRESCALER_EN to add a per-channel 2^p prescaler in ctrl[7:4].
module multi_timer #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned CNT_W = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [31:2]    Addr,
  input  logic           WE,
  input  logic [31:0]    Din,
  output logic [31:0]    Dout,
  output logic [NCH-1:0] irq_vec,
  output logic           IRQ
);

  typedef enum logic [1:0] {IDLE, LOAD, CNT, EXPIRE} state_t;

  localparam logic [1:0]       REG_CTRL   = 2'd0;
  localparam logic [1:0]       REG_PRESET = 2'd1;
  localparam logic [1:0]       REG_COUNT  = 2'd2;
  localparam logic [1:0]       REG_STATUS = 2'd3;
  localparam logic [1:0]       MODE_AUTO  = 2'b01;
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

  state_t           state_q   [NCH];
  state_t           state_d   [NCH];
  logic             en_q      [NCH];
  logic             en_d      [NCH];
  logic [1:0]       mode_q    [NCH];
  logic [1:0]       mode_d    [NCH];
  logic             mask_q    [NCH];
  logic             mask_d    [NCH];
  logic [CNT_W-1:0] preset_q  [NCH];
  logic [CNT_W-1:0] preset_d  [NCH];
  logic [CNT_W-1:0] count_q   [NCH];
  logic [CNT_W-1:0] count_d   [NCH];
  logic             pending_q [NCH];
  logic             pending_d [NCH];
  logic             pend_set  [NCH];
  logic             pend_clr  [NCH];
  logic             tick      [NCH];
`ifdef MULTI_TIMER_PRESCALER_EN
  logic [3:0]       presc_q   [NCH];
  logic [3:0]       presc_d   [NCH];
  logic [14:0]      pdiv_q    [NCH];
  logic [14:0]      pdiv_d    [NCH];
`endif

  logic [1:0] sel_ch;
  logic [1:0] sel_reg;
  logic       unused_bits;

  assign sel_ch      = Addr[5:4];
  assign sel_reg     = Addr[3:2];
  assign unused_bits = ^{Addr[31:6], Din};

  // A decrement tick fires when the prescale divider reaches 2^p - 1.
  always_comb begin
    for (int unsigned c = 0; c < NCH; c++) begin
`ifdef MULTI_TIMER_PRESCALER_EN
      tick[c] = ({1'b0, pdiv_q[c]} == ((16'd1 << presc_q[c]) - 16'd1));
`else
      tick[c] = 1'b1;
`endif
    end
  end

  // Next-state logic: a register write to a channel freezes that channel's FSM for the cycle.
  always_comb begin
    for (int unsigned c = 0; c < NCH; c++) begin
      state_d[c]  = state_q[c];
      en_d[c]     = en_q[c];
      mode_d[c]   = mode_q[c];
      mask_d[c]   = mask_q[c];
      preset_d[c] = preset_q[c];
      count_d[c]  = count_q[c];
      pend_set[c] = 1'b0;
      pend_clr[c] = 1'b0;
`ifdef MULTI_TIMER_PRESCALER_EN
      presc_d[c]  = presc_q[c];
      pdiv_d[c]   = pdiv_q[c];
`endif
      if (WE && (sel_ch == 2'(c))) begin
`ifdef MULTI_TIMER_PRESCALER_EN
        pdiv_d[c] = '0;
`endif
        unique case (sel_reg)
          REG_CTRL: begin
            en_d[c]   = Din[0];
            mode_d[c] = Din[2:1];
            mask_d[c] = Din[3];
`ifdef MULTI_TIMER_PRESCALER_EN
            presc_d[c] = Din[7:4];
`endif
          end
          REG_PRESET: preset_d[c] = Din[CNT_W-1:0];
          REG_COUNT:  count_d[c]  = Din[CNT_W-1:0];
          REG_STATUS: pend_clr[c] = Din[0];
        endcase
      end else begin
        unique case (state_q[c])
          IDLE: begin
            if (en_q[c]) state_d[c] = LOAD;
          end
          LOAD: begin
            count_d[c] = preset_q[c];
            state_d[c] = CNT;
`ifdef MULTI_TIMER_PRESCALER_EN
            pdiv_d[c]  = '0;
`endif
          end
          CNT: begin
            if (!en_q[c]) begin
              state_d[c] = IDLE;
            end else begin
              if (tick[c]) begin
                if (count_q[c] > ONE) begin
                  count_d[c] = count_q[c] - ONE;
                end else begin
                  count_d[c]  = '0;
                  pend_set[c] = 1'b1;
                  state_d[c]  = EXPIRE;
                end
              end
`ifdef MULTI_TIMER_PRESCALER_EN
              pdiv_d[c] = tick[c] ? '0 : pdiv_q[c] + 15'd1;
`endif
            end
          end
          EXPIRE: begin
`ifdef MULTI_TIMER_PRESCALER_EN
            pdiv_d[c] = '0;
`endif
            if (mode_q[c] == MODE_AUTO) begin
              count_d[c] = preset_q[c];
              state_d[c] = CNT;
            end else begin
              en_d[c]    = 1'b0;
              state_d[c] = IDLE;
            end
          end
        endcase
      end
      // A set from the FSM takes precedence over a same-cycle clear.
      pending_d[c] = pend_set[c] | (pending_q[c] & ~pend_clr[c]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned c = 0; c < NCH; c++) begin
        state_q[c]   <= IDLE;
        en_q[c]      <= 1'b0;
        mode_q[c]    <= '0;
        mask_q[c]    <= 1'b0;
        preset_q[c]  <= '0;
        count_q[c]   <= '0;
        pending_q[c] <= 1'b0;
`ifdef MULTI_TIMER_PRESCALER_EN
        presc_q[c]   <= '0;
        pdiv_q[c]    <= '0;
`endif
      end
    end else begin
      for (int unsigned c = 0; c < NCH; c++) begin
        state_q[c]   <= state_d[c];
        en_q[c]      <= en_d[c];
        mode_q[c]    <= mode_d[c];
        mask_q[c]    <= mask_d[c];
        preset_q[c]  <= preset_d[c];
        count_q[c]   <= count_d[c];
        pending_q[c] <= pending_d[c];
`ifdef MULTI_TIMER_PRESCALER_EN
        presc_q[c]   <= presc_d[c];
        pdiv_q[c]    <= pdiv_d[c];
`endif
      end
    end
  end

  always_comb begin
    Dout = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      if (sel_ch == 2'(c)) begin
        unique case (sel_reg)
`ifdef MULTI_TIMER_PRESCALER_EN
          REG_CTRL:   Dout = 32'({presc_q[c], mask_q[c], mode_q[c], en_q[c]});
`else
          REG_CTRL:   Dout = 32'({mask_q[c], mode_q[c], en_q[c]});
`endif
          REG_PRESET: Dout = 32'(preset_q[c]);
          REG_COUNT:  Dout = 32'(count_q[c]);
          REG_STATUS: Dout = 32'(pending_q[c]);
        endcase
      end
    end
  end

  always_comb begin
    for (int unsigned c = 0; c < NCH; c++) begin
      irq_vec[c] = pending_q[c] & mask_q[c];
    end
  end

  assign IRQ = |irq_vec;

endmodule
